// File: rtl/rsa_operand_fetch_if.sv
// rsa_operand_fetch_if: SRAM read port and tagged word stream of the RSA operand fetcher.
//   sram_en/sram_addr : read request, address sampled by the SRAM at the next edge
//   sram_data         : read data, valid the cycle after the enabled edge
//   out_valid/ready   : stream handshake, word moves when both are high at an edge
//   out_data/tag/index/last : stream word, region tag (2=N, 1=key, 0=msg), index, last-of-region
//   master modport is the fetcher, slave modport is the SRAM plus consuming core.
interface rsa_operand_fetch_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          sram_en;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_tag;
    logic [5:0]    out_index;
    logic          out_last;

    modport master (
        output sram_en, sram_addr, out_valid, out_data, out_tag, out_index, out_last,
        input  sram_data, out_ready
    );

    modport slave (
        input  sram_en, sram_addr, out_valid, out_data, out_tag, out_index, out_last,
        output sram_data, out_ready
    );
endinterface

// File: rtl/rsa_operand_fetch.sv
// rsa_operand_fetch: drains the N, key and message regions of the operand SRAM into a tagged stream.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   start : single-cycle request, honoured only in IDLE
//   busy  : high while the three regions are being fetched and drained
//   done  : one-cycle pulse the cycle after the final word handshake
//   bus   : master side of rsa_operand_fetch_if (SRAM read port and output stream)
module rsa_operand_fetch #(
    parameter int WORDS    = 64,
    parameter int MSG_BASE = 0,
    parameter int KEY_BASE = 64,
    parameter int MOD_BASE = 128,
    parameter int AW       = 8,
    parameter int DW       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    rsa_operand_fetch_if.master   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [1:0]    tag;
        logic [5:0]    idx;
        logic [DW-1:0] data;
    } entry_t;

    state_t        state_q, state_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [5:0]    rd_cnt_q, rd_cnt_d;
    logic [1:0]    region_q, region_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    inf_tag_q, inf_tag_d;
    logic [5:0]    inf_idx_q, inf_idx_d;
    entry_t        head_q, head_d, tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          issue, push, pop, region_end;
    logic [1:0]    slot;
    logic [AW-1:0] issue_addr;
    entry_t        new_ent;

    always_comb begin
        pop        = (cnt_q != 2'd0) && bus.out_ready;
        push       = inflight_q;
        // Buffered words plus the word still in the SRAM pipe never exceed two.
        issue      = (state_q == FETCH) &&
                     (({1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
        region_end = rd_cnt_q == 6'(WORDS - 1);
        issue_addr = (region_q == 2'd2 ? AW'(MOD_BASE) :
                      region_q == 2'd1 ? AW'(KEY_BASE) : AW'(MSG_BASE)) + AW'(rd_cnt_q);
        new_ent    = '{tag: inf_tag_q, idx: inf_idx_q, data: bus.sram_data};
        // Two-entry shift buffer: a pop moves tail to head, the landing word fills the first free slot.
        slot       = cnt_q - {1'b0, pop};
        head_d     = pop ? tail_q : head_q;
        tail_d     = tail_q;
        if (push && slot == 2'd0) head_d = new_ent;
        if (push && slot != 2'd0) tail_d = new_ent;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        addr_d     = issue ? issue_addr : addr_q;
        inflight_d = issue;
        inf_tag_d  = issue ? region_q : inf_tag_q;
        inf_idx_d  = issue ? rd_cnt_q : inf_idx_q;
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        region_d   = region_q;
        if (state_q == IDLE && start) begin
            state_d  = FETCH;
            rd_cnt_d = 6'd0;
            region_d = 2'd2;
        end
        if (issue) begin
            rd_cnt_d = region_end ? 6'd0 : rd_cnt_q + 6'd1;
            region_d = region_end ? region_q - 2'd1 : region_q;
            state_d  = (region_end && region_q == 2'd0) ? DRAIN : state_q;
        end
        // Looking at next-cycle occupancy lets done land right after the final handshake.
        if (state_q == DRAIN && cnt_d == 2'd0 && !inflight_d) state_d = DONE;
        if (state_q == DONE) state_d = IDLE;
        busy_d     = (state_d == FETCH) || (state_d == DRAIN);
        done_d     = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_cnt_q   <= '0;
            region_q   <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            inf_tag_q  <= '0;
            inf_idx_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_cnt_q   <= rd_cnt_d;
            region_q   <= region_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            inf_tag_q  <= inf_tag_d;
            inf_idx_q  <= inf_idx_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.sram_en   = issue;
    assign bus.sram_addr = issue ? issue_addr : addr_q;
    assign bus.out_valid = cnt_q != 2'd0;
    assign bus.out_data  = head_q.data;
    assign bus.out_tag   = head_q.tag;
    assign bus.out_index = head_q.idx;
    assign bus.out_last  = (cnt_q != 2'd0) && (head_q.idx == 6'(WORDS - 1));

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && cnt_q == 2'd2));
endmodule

// File: tb/tb_rsa_operand_fetch.sv
// tb_rsa_operand_fetch: scoreboard bench for rsa_operand_fetch with an address-valued SRAM model.
module tb_rsa_operand_fetch;
    typedef struct {
        logic [1:0]  tag;
        logic [5:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done;
    logic [31:0] mem [256];
    exp_t sb [$];
    int checks = 0;
    int errors = 0;
    int outstanding = 0;
    int issued = 0;
    int popped = 0;
    bit mon_en = 0;
    bit exp_done = 0;
    bit done_seen = 0;
    bit hold_v = 0;
    bit rnd_mode = 0;
    bit ready_fix = 1'b1;
    logic [31:0] hold_data;
    logic [1:0]  hold_tag;
    logic [5:0]  hold_idx;

    rsa_operand_fetch_if #(.AW(8), .DW(32)) bus ();

    rsa_operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.sram_en) bus.sram_data <= mem[bus.sram_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.out_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : ready_fix;
    endtask

    task automatic load_sb();
        exp_t e;
        for (int r = 2; r >= 0; r--)
            for (int i = 0; i < 64; i++) begin
                e.tag  = 2'(r);
                e.idx  = 6'(i);
                e.data = 32'(r * 64 + i);
                sb.push_back(e);
            end
    endtask

    task automatic start_xfer();
        load_sb();
        issued = 0;
        popped = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_en", bus.sram_en, 1);
        check("first_addr", bus.sram_addr, 128);
        check("busy_rise", busy, 1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 3000 && !done_seen; n++) tick();
        check("done_seen", done_seen, 1);
        done_seen = 0;
        tick();
        check("busy_after", busy, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic wait_popped(input int k);
        for (int n = 0; n < 2000 && popped < k; n++) tick();
        check("reach_word", popped >= k, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            outstanding = 0;
            hold_v = 0;
            exp_done = 0;
        end else begin
            if (hold_v) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, hold_data);
                check("hold_tag", bus.out_tag, hold_tag);
                check("hold_index", bus.out_index, hold_idx);
            end
            if (done || exp_done) check("done_pulse", done, exp_done);
            if (done) done_seen = 1;
            exp_done = 0;
            if (bus.sram_en) begin
                outstanding++;
                issued++;
            end
            if (bus.out_valid && bus.out_ready) begin
                outstanding--;
                popped++;
                if (sb.size() == 0) check("extra_word", bus.out_index, 8'hff);
                else begin
                    e = sb.pop_front();
                    check("data", bus.out_data, e.data);
                    check("tag", bus.out_tag, e.tag);
                    check("index", bus.out_index, e.idx);
                    check("last", bus.out_last, e.idx == 6'd63);
                    if (e.tag == 2'd0 && e.idx == 6'd63) exp_done = 1;
                end
            end
            if (busy) check("occ_le2", outstanding > 2, 0);
            hold_v = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            hold_tag = bus.out_tag;
            hold_idx = bus.out_index;
        end
    end

    initial begin
        int vcount;
        for (int a = 0; a < 256; a++) mem[a] = 32'(a);
        bus.out_ready = 1'b1;
        // Reset held with start asserted
        start = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            check("rst_outs", {busy, done, bus.sram_en, bus.sram_addr, bus.out_valid,
                               bus.out_data, bus.out_tag, bus.out_index, bus.out_last}, 0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        check("idle_en", bus.sram_en, 0);
        mon_en = 1;
        // Full-rate stream
        start_xfer();
        vcount = 0;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (bus.out_valid) vcount++;
            else if (vcount > 0) break;
        end
        check("valid_run", vcount, 192);
        wait_done();
        // Random backpressure
        rnd_mode = 1;
        start_xfer();
        wait_done();
        rnd_mode = 0;
        // Long stall after first valid
        ready_fix = 1'b0;
        tick();
        start_xfer();
        for (int n = 0; n < 20 && !bus.out_valid; n++) tick();
        check("stall_valid0", bus.out_valid, 1);
        for (int n = 0; n < 20; n++) tick();
        check("stall_reads", issued, 2);
        check("stall_valid", bus.out_valid, 1);
        check("stall_head", bus.out_data, 128);
        ready_fix = 1'b1;
        wait_done();
        // Second start mid-transfer is ignored
        start_xfer();
        wait_popped(50);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_mid", busy, 1);
        wait_done();
        // Reset mid-transfer then restart
        start_xfer();
        wait_popped(100);
        rst_n = 1'b0;
        mon_en = 0;
        tick();
        check("midrst_outs", {busy, done, bus.sram_en, bus.sram_addr, bus.out_valid,
                              bus.out_data, bus.out_tag, bus.out_index, bus.out_last}, 0);
        rst_n = 1'b1;
        sb.delete();
        done_seen = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("no_done", done, 0);
        end
        mon_en = 1;
        start_xfer();
        wait_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
